// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: accumulates coin credit, sells one of
// NUM_ITEMS products at per-item prices, tracks per-item stock, returns
// change, and refunds on cancel or after an inactivity timeout.
//
// Handshake: every input request (coin_valid, sel_valid, cancel,
// restock_valid) is a single-cycle strobe sampled on the rising clock edge;
// there is no ready signal. A request is either acted on in that cycle or
// answered by a one-cycle pulse (coin_reject, err_insufficient,
// err_sold_out) or silently ignored (sel/cancel while busy).
module vending_machine_multi #(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W = 2,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd30, 8'd50, 8'd20, 8'd10},
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 7,
  parameter int TIMEOUT = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic [CREDIT_W-1:0]  coin_value,
  input  logic                 sel_valid,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 cancel,
  input  logic                 restock_valid,
  input  logic [SEL_W-1:0]     restock_item,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 vend_valid,
  output logic [SEL_W-1:0]     vend_item,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change,
  output logic                 coin_reject,
  output logic                 err_insufficient,
  output logic                 err_sold_out,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t state;

  logic [STOCK_W-1:0]  stock [NUM_ITEMS];
  logic [TO_W-1:0]     idle_cnt;

  logic                coin_in;
  logic [CREDIT_W:0]   sum;
  logic                coin_ovf;
  logic                sel_in_range;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_avail;
  logic                sel_afford;
  logic                timed_out;

  // Decode the current request against registered credit and stock.
  always_comb begin
    coin_in      = coin_valid && (coin_value != '0);
    sum          = {1'b0, credit} + {1'b0, coin_value};
    coin_ovf     = sum[CREDIT_W];
    sel_in_range = int'(sel) < NUM_ITEMS;
    sel_stock    = '0;
    sel_price    = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (int'(sel) == i) begin
        sel_stock = stock[i];
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    sel_avail  = sel_in_range && (sel_stock != '0);
    sel_afford = credit >= sel_price;
    timed_out  = idle_cnt == TO_LAST;
  end

  // Sold-out flags follow the stock counters directly.
  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out[i] = stock[i] == '0;
    end
  end

  // Main controller: state, credit, timeout counter and all registered outputs.
  // vend_item and change double as the latched item and change amount.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      credit           <= '0;
      idle_cnt         <= '0;
      vend_valid       <= 1'b0;
      vend_item        <= '0;
      change_valid     <= 1'b0;
      change           <= '0;
      coin_reject      <= 1'b0;
      err_insufficient <= 1'b0;
      err_sold_out     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      vend_valid       <= 1'b0;
      change_valid     <= 1'b0;
      coin_reject      <= 1'b0;
      err_insufficient <= 1'b0;
      err_sold_out     <= 1'b0;
      case (state)
        S_IDLE: begin
          idle_cnt <= '0;
          busy     <= 1'b0;
          if (sel_valid) begin
            err_insufficient <= 1'b1;
          end
          if (coin_in) begin
            credit <= coin_value;
            state  <= S_CREDIT;
          end
        end
        S_CREDIT: begin
          if (cancel || (timed_out && !coin_in && !sel_valid)) begin
            // Refund everything; a coin arriving now is handed back.
            change       <= credit;
            credit       <= '0;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            idle_cnt     <= '0;
            state        <= S_CHANGE;
            if (coin_in) begin
              coin_reject <= 1'b1;
            end
          end else if (sel_valid && sel_avail && sel_afford) begin
            vend_item  <= sel;
            change     <= credit - sel_price;
            credit     <= '0;
            vend_valid <= 1'b1;
            busy       <= 1'b1;
            idle_cnt   <= '0;
            state      <= S_VEND;
            if (coin_in) begin
              coin_reject <= 1'b1;
            end
          end else begin
            // Failed selection (if any) still lets a coin through.
            if (sel_valid) begin
              if (!sel_avail) begin
                err_sold_out <= 1'b1;
              end else begin
                err_insufficient <= 1'b1;
              end
            end
            if (coin_in) begin
              if (coin_ovf) begin
                coin_reject <= 1'b1;
              end else begin
                credit <= sum[CREDIT_W-1:0];
              end
            end
            if (sel_valid || coin_in) begin
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + TO_W'(1);
            end
          end
        end
        S_VEND: begin
          if (coin_in) begin
            coin_reject <= 1'b1;
          end
          if (change != '0) begin
            change_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= S_CHANGE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_CHANGE: begin
          if (coin_in) begin
            coin_reject <= 1'b1;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stock counters: restock saturates the item, a vend decrements it;
  // restock of the item being vended in the same cycle takes precedence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock[i] <= STOCK_RST;
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (restock_valid && (int'(restock_item) == i)) begin
          stock[i] <= STOCK_MAX;
        end else if ((state == S_VEND) && (int'(vend_item) == i)) begin
          stock[i] <= stock[i] - STOCK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios with literal
// expectations, then randomized traffic, all compared each cycle against a
// transaction-level model of the machine.
module tb_vending_machine_multi;

  localparam int NUM_ITEMS  = 4;
  localparam int SEL_W      = 3;
  localparam int CREDIT_W   = 8;
  localparam int STOCK_W    = 4;
  localparam int STOCK_INIT = 7;
  localparam int TIMEOUT    = 16;
  localparam int CREDIT_MAX = 255;
  localparam int STOCK_FULL = 15;

  // Item prices: 0 -> 10, 1 -> 50, 2 -> 20, 3 -> 30.
  int price_tbl [NUM_ITEMS] = '{10, 50, 20, 30};
  int coin_tbl [7] = '{0, 5, 10, 20, 50, 100, 200};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 coin_valid = 1'b0;
  logic [CREDIT_W-1:0]  coin_value = '0;
  logic                 sel_valid = 1'b0;
  logic [SEL_W-1:0]     sel = '0;
  logic                 cancel = 1'b0;
  logic                 restock_valid = 1'b0;
  logic [SEL_W-1:0]     restock_item = '0;
  logic [CREDIT_W-1:0]  credit;
  logic                 vend_valid;
  logic [SEL_W-1:0]     vend_item;
  logic                 change_valid;
  logic [CREDIT_W-1:0]  change;
  logic                 coin_reject;
  logic                 err_insufficient;
  logic                 err_sold_out;
  logic [NUM_ITEMS-1:0] sold_out;
  logic                 busy;

  vending_machine_multi #(
    .NUM_ITEMS(NUM_ITEMS),
    .SEL_W(SEL_W),
    .CREDIT_W(CREDIT_W),
    .PRICES({8'd30, 8'd20, 8'd50, 8'd10}),
    .STOCK_W(STOCK_W),
    .STOCK_INIT(STOCK_INIT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .coin_valid(coin_valid),
    .coin_value(coin_value),
    .sel_valid(sel_valid),
    .sel(sel),
    .cancel(cancel),
    .restock_valid(restock_valid),
    .restock_item(restock_item),
    .credit(credit),
    .vend_valid(vend_valid),
    .vend_item(vend_item),
    .change_valid(change_valid),
    .change(change),
    .coin_reject(coin_reject),
    .err_insufficient(err_insufficient),
    .err_sold_out(err_sold_out),
    .sold_out(sold_out),
    .busy(busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Credit of zero means the machine is waiting for a first coin. A sale or
  // refund makes the machine busy; pending change amounts wait in exp_q and
  // each one occupies one further busy cycle.
  int m_credit;
  int m_stock [NUM_ITEMS];
  logic [CREDIT_W-1:0] exp_q[$];
  int edge_n;
  int last_act;
  bit e_busy, e_vend, e_chg_v, e_rej, e_ins, e_so;
  int e_item, e_chg;

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
    exp_q.delete();
    edge_n = 0;
    last_act = 0;
    e_busy = 0; e_vend = 0; e_chg_v = 0; e_rej = 0; e_ins = 0; e_so = 0;
    e_item = 0; e_chg = 0;
  endtask

  task automatic model_step();
    bit was_vend, coin_in;
    int was_item, cv, s, price, rest;
    was_vend = e_vend;
    was_item = e_item;
    e_vend = 0; e_chg_v = 0; e_rej = 0; e_ins = 0; e_so = 0;
    edge_n++;
    cv = int'(coin_value);
    s = int'(sel);
    coin_in = coin_valid && (cv != 0);
    if (e_busy) begin
      if (coin_in) e_rej = 1;
      if (exp_q.size() > 0) begin
        e_chg_v = 1;
        e_chg = int'(exp_q.pop_front());
      end else begin
        e_busy = 0;
      end
    end else if (m_credit == 0) begin
      if (sel_valid) e_ins = 1;
      if (coin_in) begin
        m_credit = cv;
        last_act = edge_n;
      end
    end else if (cancel || (!coin_in && !sel_valid && (edge_n - last_act == TIMEOUT))) begin
      e_chg_v = 1;
      e_chg = m_credit;
      m_credit = 0;
      e_busy = 1;
      if (coin_in) e_rej = 1;
    end else begin
      bit sold = 0;
      if (sel_valid) begin
        if (s >= NUM_ITEMS || m_stock[s] == 0) begin
          e_so = 1;
        end else begin
          price = price_tbl[s];
          if (m_credit < price) begin
            e_ins = 1;
          end else begin
            rest = m_credit - price;
            m_credit = 0;
            e_busy = 1;
            e_vend = 1;
            e_item = s;
            if (rest != 0) exp_q.push_back(CREDIT_W'(rest));
            if (coin_in) e_rej = 1;
            sold = 1;
          end
        end
      end
      if (!sold && coin_in) begin
        if (m_credit + cv > CREDIT_MAX) e_rej = 1;
        else m_credit = m_credit + cv;
      end
      if (sel_valid || coin_in) last_act = edge_n;
    end
    if (was_vend) m_stock[was_item] = m_stock[was_item] - 1;
    if (restock_valid && int'(restock_item) < NUM_ITEMS) m_stock[int'(restock_item)] = STOCK_FULL;
  endtask

  // Model advances on each clock edge and is cleared by reset at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic compare_all();
    int exp_so;
    exp_so = 0;
    for (int i = 0; i < NUM_ITEMS; i++) if (m_stock[i] == 0) exp_so |= (1 << i);
    chk("credit", int'(credit), m_credit);
    chk("busy", int'(busy), int'(e_busy));
    chk("vend_valid", int'(vend_valid), int'(e_vend));
    if (e_vend) chk("vend_item", int'(vend_item), e_item);
    chk("change_valid", int'(change_valid), int'(e_chg_v));
    if (e_chg_v) chk("change", int'(change), e_chg);
    chk("coin_reject", int'(coin_reject), int'(e_rej));
    chk("err_insufficient", int'(err_insufficient), int'(e_ins));
    chk("err_sold_out", int'(err_sold_out), int'(e_so));
    chk("sold_out", int'(sold_out), exp_so);
  endtask

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (rst_n) compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit cv, input int cval, input bit sv, input int s,
                       input bit cn, input bit rv, input int ri);
    coin_valid = cv;
    coin_value = CREDIT_W'(cval);
    sel_valid = sv;
    sel = SEL_W'(s);
    cancel = cn;
    restock_valid = rv;
    restock_item = SEL_W'(ri);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic coin(input int v);
    drive(1, v, 0, 0, 0, 0, 0);
  endtask

  task automatic buy(input int s);
    drive(0, 0, 1, s, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset credit", int'(credit), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset vend_valid", int'(vend_valid), 0);
    chk("reset sold_out", int'(sold_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Insufficient credit, then a sale with change.
    coin(20);
    coin(20);
    buy(1);
    chk("t1 err_insufficient", int'(err_insufficient), 1);
    chk("t1 credit40", int'(credit), 40);
    coin(20);
    chk("t1 credit60", int'(credit), 60);
    buy(1);
    chk("t1 vend_valid", int'(vend_valid), 1);
    chk("t1 vend_item", int'(vend_item), 1);
    chk("t1 credit0", int'(credit), 0);
    idle(1);
    chk("t1 change_valid", int'(change_valid), 1);
    chk("t1 change", int'(change), 10);
    idle(1);
    chk("t1 idle busy", int'(busy), 0);

    // Exact payment: no change pulse.
    coin(10);
    buy(0);
    chk("t2 vend_item", int'(vend_item), 0);
    idle(1);
    chk("t2 no change", int'(change_valid), 0);
    chk("t2 busy", int'(busy), 0);

    // Cancel with a coin in the same cycle.
    coin(30);
    drive(1, 10, 0, 0, 1, 0, 0);
    chk("t3 coin_reject", int'(coin_reject), 1);
    chk("t3 refund", int'(change), 30);
    chk("t3 change_valid", int'(change_valid), 1);
    idle(1);

    // Inactivity timeout refunds after TIMEOUT idle cycles.
    coin(30);
    idle(TIMEOUT - 1);
    chk("t4 still credit", int'(credit), 30);
    idle(1);
    chk("t4 timeout refund", int'(change_valid), 1);
    chk("t4 timeout amount", int'(change), 30);
    idle(1);

    // Overflowing coin is rejected.
    coin(100);
    coin(100);
    coin(50);
    coin(10);
    chk("t5 overflow reject", int'(coin_reject), 1);
    chk("t5 credit250", int'(credit), 250);
    buy(3);
    chk("t5 vend_item", int'(vend_item), 3);
    idle(1);
    chk("t5 change220", int'(change), 220);
    idle(1);

    // Drain item 2, sold-out path, then restock.
    for (int i = 0; i < STOCK_INIT; i++) begin
      coin(20);
      buy(2);
      idle(1);
    end
    chk("t6 sold_out2", int'(sold_out[2]), 1);
    coin(20);
    buy(2);
    chk("t6 err_sold_out", int'(err_sold_out), 1);
    chk("t6 credit kept", int'(credit), 20);
    drive(0, 0, 0, 0, 0, 1, 2);
    chk("t6 restocked", int'(sold_out[2]), 0);
    buy(2);
    chk("t6 vend after restock", int'(vend_valid), 1);
    idle(1);

    // Out-of-range index.
    coin(10);
    buy(4);
    chk("t7 invalid sel", int'(err_sold_out), 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // Reset during the vend cycle aborts everything.
    coin(10);
    buy(0);
    #2 rst_n = 1'b0;
    #1;
    chk("t8 vend aborted", int'(vend_valid), 0);
    chk("t8 busy", int'(busy), 0);
    chk("t8 sold_out", int'(sold_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        idle($urandom_range(10, 20));
      end else begin
        drive($urandom_range(0, 99) < 40, coin_tbl[$urandom_range(0, 6)],
              $urandom_range(0, 99) < 15,
              ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7),
              $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 3, $urandom_range(0, 7));
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised multi-item vending controller, successor to the fixed three-item machine. Accumulates credit from a coin stream over many cycles. Sells one of NUM_ITEMS products at per-item prices, tracks per-item stock, returns change, and supports cancel/refund and an inactivity timeout. Sits between the coin acceptor/keypad front end and the dispense/change actuators.

Parameters:
NUM_ITEMS, 4, number of products; must be >= 2
SEL_W, 2, select width; must be >= clog2(NUM_ITEMS)
CREDIT_W, 8, width of credit, coin, price and change values
PRICES, {8'd30,8'd50,8'd20,8'd10}, packed prices; item i at bits [i*CREDIT_W +: CREDIT_W]; each price must be nonzero
STOCK_W, 4, width of each stock counter
STOCK_INIT, 7, stock of every item after reset; must be <= 2^STOCK_W-1
TIMEOUT, 100, idle cycles in CREDIT before auto-refund; must be >= 2

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  asynchronous, active-low reset
coin_valid  in  1  coin present this cycle
coin_value  in  CREDIT_W  coin value; zero value is ignored
sel_valid  in  1  purchase request this cycle
sel  in  SEL_W  requested item index
cancel  in  1  refund request
restock_valid  in  1  refill request
restock_item  in  SEL_W  item to refill
credit  out  CREDIT_W  current accumulated credit
vend_valid  out  1  one-cycle dispense pulse
vend_item  out  SEL_W  item dispensed; valid only with vend_valid
change_valid  out  1  one-cycle change/refund pulse
change  out  CREDIT_W  change amount; valid only with change_valid
coin_reject  out  1  one-cycle pulse: coin returned, not credited
err_insufficient  out  1  one-cycle pulse: credit is below the price
err_sold_out  out  1  one-cycle pulse: stock is 0 or the index is invalid
sold_out  out  NUM_ITEMS  bit i is 1 when stock[i]==0 (combinational from stock)
busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset (asynchronous, active low):
  - state=IDLE, credit=0, timeout counter=0.
  - All pulses and busy are 0; vend_item=0, change=0.
  - Every stock[i] is set to STOCK_INIT. A reset mid-VEND or mid-CHANGE aborts with no vend and no change.
- All outputs are registered except sold_out. Every pulse lasts exactly one cycle.
- States: IDLE, CREDIT, VEND, CHANGE.
- Priority in IDLE/CREDIT, evaluated against the registered credit: cancel > sel_valid > coin_valid.
- IDLE:
  - An accepted nonzero coin sets credit=coin_value and moves to CREDIT.
  - sel_valid raises err_insufficient. cancel is ignored.
- CREDIT:
  - Coin: credit += coin_value. If the sum exceeds 2^CREDIT_W-1, coin_reject pulses and credit is unchanged.
  - sel_valid, invalid index (sel >= NUM_ITEMS) or stock 0: err_sold_out pulses. A coin in the same cycle is still processed.
  - sel_valid, credit < price: err_insufficient pulses. A coin in the same cycle is still processed.
  - sel_valid, credit >= price: latch item and change=credit-price, clear credit, go to VEND. A coin in the same cycle gets coin_reject.
  - cancel: change=credit, credit=0, go to CHANGE. A coin in the same cycle gets coin_reject.
  - Timeout counter clears on any coin, select or cancel and otherwise increments. When it reaches TIMEOUT-1, the machine behaves as cancel.
- VEND (one cycle):
  - vend_valid=1 and vend_item=latched item.
  - stock[item] decrements at the end of this cycle.
  - Next state is CHANGE if the latched change is nonzero, else IDLE.
- CHANGE (one cycle): change_valid=1 with the latched change, then IDLE.
- In VEND and CHANGE: coins get coin_reject; sel and cancel are ignored.
- Latency:
  - Select accepted at edge k: vend_valid is high in cycle k..k+1 and change_valid in cycle k+1..k+2.
  - Cancel accepted at edge k: change_valid is high in cycle k..k+1.
- Restock:
  - Honoured in any state. stock[restock_item] is set to 2^STOCK_W-1; an invalid index is ignored.
  - Restock of the item being decremented in the same cycle: restock wins.
- Stock never wraps; a decrement at 0 cannot occur because of the sold-out check.

Test Plan:
- Coins 20,20 then sel=1 (price 50) -> err_insufficient, credit=40; coin 20 -> credit 60; sel=1 -> vend_valid with vend_item=1, then change_valid with change=10; stock[1] goes 7->6; back to IDLE.
- Exact pay: coin 10, sel=0 -> vend_valid with vend_item=0, no change_valid, IDLE next; credit=0.
- STOCK_INIT=1: buy item 2 (price 20) twice -> second attempt gives err_sold_out, credit kept, sold_out[2]=1; restock_item=2 -> sold_out[2]=0 and the next sel succeeds.
- Credit 30 + cancel with a coin in the same cycle -> coin_reject, change_valid with change=30; also TIMEOUT=16 with credit 30 and no activity -> refund of 30 after 16 cycles.
- Overflow: credit 250 (CREDIT_W=8), coin 10 -> coin_reject, credit stays 250; sel=3 -> vend, change 220.
- Reset asserted in VEND cycle -> vend_valid drops immediately, all outputs 0, stock restored to STOCK_INIT; sel=4 with NUM_ITEMS=4, SEL_W=3 -> err_sold_out.
